// File: rtl/dct2_fwd4_seq_pkg.sv
// Shared constants and types for the forward 4-point DCT-II core.
//   COEF_*     : transform constants (64, 83, 36)
//   state_t    : sequencer states
//   bf_w/acc_w : width helpers for butterfly outputs and the accumulator
package dct2_fwd_pkg;

    localparam int COEF_64 = 64;
    localparam int COEF_83 = 83;
    localparam int COEF_36 = 36;

    // Default build widths; modules derive their own from their parameters.
    localparam int DIN_W_DEF  = 16;
    localparam int COEF_W_DEF = 8;
    localparam int BF_W       = DIN_W_DEF + 1;
    localparam int ACC_W      = DIN_W_DEF + COEF_W_DEF + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BFLY = 2'd1,
        MAC  = 2'd2,
        OUT  = 2'd3
    } state_t;

    function automatic int bf_w(input int din_w);
        return din_w + 1;
    endfunction

    function automatic int acc_w(input int din_w, input int coef_w);
        return din_w + coef_w + 2;
    endfunction

endpackage

// File: rtl/dct2_fwd4_seq_if.sv
// Row-in / coefficient-out stream bundle for dct2_fwd4_seq.
//   master : row source and coefficient sink (drives in_valid, in_data, out_ready)
//   slave  : the transform core
interface dct2_fwd4_seq_if #(
    parameter int DIN_W  = 16,
    parameter int DOUT_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [4*DIN_W-1:0]       in_data;   // s0 in LSBs
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DOUT_W-1:0] out_data;
    logic [1:0]               out_idx;
    logic                     out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/dct2_fwd4_seq_mac.sv
// Time-shared multiply-accumulate with round/shift/saturate.
//   clk, rst_n : clock, async active-low reset (clears the accumulator)
//   i_en       : update the accumulator this cycle
//   i_load     : 1 = acc <= p, 0 = acc <= acc + p
//   i_opnd     : butterfly operand, DIN_W+1 bits signed
//   i_coef     : transform constant, COEF_W bits signed
//   o_res      : round_clip of the value the accumulator is taking this cycle
module dct2_fwd_mac
    import dct2_fwd_pkg::*;
#(
    parameter int DIN_W  = 16,
    parameter int COEF_W = 8,
    parameter int DOUT_W = 16,
    parameter int SHIFT  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic                     i_load,
    input  logic signed [DIN_W:0]    i_opnd,
    input  logic signed [COEF_W-1:0] i_coef,
    output logic signed [DOUT_W-1:0] o_res
);
    localparam int AW = acc_w(DIN_W, COEF_W);
    localparam int PW = bf_w(DIN_W) + COEF_W;

    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_prod_x;
    logic signed [AW-1:0] w_sum;
    logic signed [AW-1:0] w_rnd;
    logic [AW-DOUT_W:0]   w_hi;
    logic signed [AW-1:0] r_acc;

    assign w_prod   = i_opnd * i_coef;
    assign w_prod_x = {{(AW-PW){w_prod[PW-1]}}, w_prod};
    assign w_sum    = i_load ? w_prod_x : (r_acc + w_prod_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (i_en)
            r_acc <= w_sum;
    end

    // Round half up, then floor via arithmetic shift.
    generate
        if (SHIFT > 0) begin : g_rnd
            localparam logic signed [AW-1:0] RND = AW'(1) <<< (SHIFT-1);
            assign w_rnd = (w_sum + RND) >>> SHIFT;
        end else begin : g_nornd
            assign w_rnd = w_sum;
        end
    endgenerate

    // Fits in DOUT_W iff every bit from the output sign bit upward agrees.
    assign w_hi = w_rnd[AW-1:DOUT_W-1];

    always_comb begin
        o_res = w_rnd[DOUT_W-1:0];
        if (!((w_hi == '0) || (w_hi == '1))) begin
            if (w_rnd[AW-1])
                o_res = {1'b1, {(DOUT_W-1){1'b0}}};
            else
                o_res = {1'b0, {(DOUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/dct2_fwd4_seq.sv
// Forward 4-point DCT-II core: one row of 4 residuals in, 4 coefficients
// out serially. Butterfly in one cycle, 8 MAC cycles on one multiplier,
// then a 4-beat valid/ready output stream.
//   ap_clk   : clock, rising edge
//   ap_rst_n : async active-low reset, aborts any row in flight
//   bus      : row input / coefficient output stream (slave side)
module dct2_fwd4_seq
    import dct2_fwd_pkg::*;
#(
    parameter int DIN_W  = 16,
    parameter int DOUT_W = 16,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 1
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    dct2_fwd4_seq_if.slave bus
);
    localparam int OPW = bf_w(DIN_W);

    state_t                   r_state, w_state_nxt;
    logic [2:0]               r_step;
    logic [1:0]               r_idx;
    logic signed [DIN_W-1:0]  r_s   [4];
    logic signed [OPW-1:0]    r_e0, r_e1, r_o0, r_o1;
    logic signed [DOUT_W-1:0] r_res [4];

    logic                     w_in_ready;
    logic                     w_out_valid;
    logic                     w_accept;
    logic                     w_out_hs;
    logic                     w_mac_en;
    logic signed [OPW-1:0]    w_opnd;
    logic signed [COEF_W-1:0] w_coef;
    logic signed [DOUT_W-1:0] w_mac_res;

    // ---------------- FSM ----------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_mac_en    = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid)
                    w_state_nxt = BFLY;
            end
            BFLY: w_state_nxt = MAC;
            MAC: begin
                w_mac_en = 1'b1;
                if (r_step == 3'd7)
                    w_state_nxt = OUT;
            end
            OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready && (r_idx == 2'd3))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = w_in_ready && bus.in_valid;
    assign w_out_hs = w_out_valid && bus.out_ready;

    // ---------------- datapath registers ----------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_s[i]   <= '0;
                r_res[i] <= '0;
            end
            r_e0   <= '0;
            r_e1   <= '0;
            r_o0   <= '0;
            r_o1   <= '0;
            r_step <= '0;
            r_idx  <= '0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < 4; i++)
                    r_s[i] <= bus.in_data[i*DIN_W +: DIN_W];
            end
            if (r_state == BFLY) begin
                r_e0 <= OPW'(r_s[0]) + OPW'(r_s[3]);
                r_e1 <= OPW'(r_s[1]) + OPW'(r_s[2]);
                r_o0 <= OPW'(r_s[0]) - OPW'(r_s[3]);
                r_o1 <= OPW'(r_s[1]) - OPW'(r_s[2]);
            end
            // 3-bit step wraps back to 0 as MAC finishes.
            if (w_mac_en) begin
                r_step <= r_step + 3'd1;
                if (r_step[0])
                    r_res[r_step[2:1]] <= w_mac_res;
            end
            // Wraps to 0 after the last beat, ready for the next row.
            if (w_out_hs)
                r_idx <= r_idx + 2'd1;
        end
    end

    // ---------------- operand schedule ----------------
    // Even step loads the first term of coefficient k, odd step adds the second.
    always_comb begin
        w_opnd = '0;
        w_coef = '0;
        case (r_step)
            3'd0: begin w_opnd = r_e0; w_coef = COEF_W'(COEF_64);  end
            3'd1: begin w_opnd = r_e1; w_coef = COEF_W'(COEF_64);  end
            3'd2: begin w_opnd = r_o0; w_coef = COEF_W'(COEF_83);  end
            3'd3: begin w_opnd = r_o1; w_coef = COEF_W'(COEF_36);  end
            3'd4: begin w_opnd = r_e0; w_coef = COEF_W'(COEF_64);  end
            3'd5: begin w_opnd = r_e1; w_coef = COEF_W'(-COEF_64); end
            3'd6: begin w_opnd = r_o0; w_coef = COEF_W'(COEF_36);  end
            3'd7: begin w_opnd = r_o1; w_coef = COEF_W'(-COEF_83); end
            default: ;
        endcase
    end

    dct2_fwd_mac #(
        .DIN_W  (DIN_W),
        .COEF_W (COEF_W),
        .DOUT_W (DOUT_W),
        .SHIFT  (SHIFT)
    ) u_mac (
        .clk    (ap_clk),
        .rst_n  (ap_rst_n),
        .i_en   (w_mac_en),
        .i_load (~r_step[0]),
        .i_opnd (w_opnd),
        .i_coef (w_coef),
        .o_res  (w_mac_res)
    );

    // ---------------- outputs ----------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_idx   = r_idx;
    assign bus.out_last  = w_out_valid && (r_idx == 2'd3);
    // Zero outside OUT so the bus is quiet while idle or busy.
    assign bus.out_data  = w_out_valid ? r_res[r_idx] : '0;

endmodule

// File: tb/tb_dct2_fwd4_seq.sv
module tb_dct2_fwd4_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dct2_fwd4_seq_if #(.DIN_W(16), .DOUT_W(16)) bus ();
    dct2_fwd4_seq_if #(.DIN_W(16), .DOUT_W(16)) bus0 ();

    dct2_fwd4_seq #(.DIN_W(16), .DOUT_W(16), .COEF_W(8), .SHIFT(1)) u_dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus)
    );

    dct2_fwd4_seq #(.DIN_W(16), .DOUT_W(16), .COEF_W(8), .SHIFT(0)) u_dut_s0 (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus0)
    );

    int checks   = 0;
    int failures = 0;
    int ex [4];
    int exa [4];

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int a, input int b,
                                         input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    // Presents a row for one cycle; returns at the negedge after the accept edge.
    task automatic send(input int a, input int b, input int c, input int d);
        @(negedge clk);
        chk("in_ready_before_accept", bus.in_ready, 1);
        bus.in_data  = pack(a, b, c, d);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Collects 4 coefficients against ex[]; optional stall at one index.
    task automatic get_row(input string tag, input bit check_lat,
                           input int stall_idx, input int stall_len);
        int n;
        n = 0;
        while (!bus.out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (check_lat) chk({tag, "_latency"}, n, 9);
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!bus.out_valid && n < 30) begin
                @(negedge clk);
                n++;
            end
            chk({tag, "_valid"}, bus.out_valid, 1);
            if (i == stall_idx) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    chk({tag, "_stall_data"}, $signed(bus.out_data), ex[i]);
                    chk({tag, "_stall_idx"}, bus.out_idx, i);
                    chk({tag, "_stall_in_ready"}, bus.in_ready, 0);
                end
                bus.out_ready = 1'b1;
            end
            chk({tag, "_data"}, $signed(bus.out_data), ex[i]);
            chk({tag, "_idx"}, bus.out_idx, i);
            chk({tag, "_last"}, bus.out_last, (i == 3) ? 1 : 0);
            @(negedge clk);
        end
        chk({tag, "_done_valid"}, bus.out_valid, 0);
        chk({tag, "_done_in_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        int n, got, cnt;
        bit took;

        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;
        bus0.in_valid  = 1'b0;
        bus0.in_data   = '0;
        bus0.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", $signed(bus.out_data), 0);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_out_last", bus.out_last, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        // Nominal row
        send(10, 20, 30, 40);
        ex = '{3200, -1425, 0, -125};
        get_row("nominal", 1'b1, -1, 0);

        // Saturation, both polarities
        send(32767, 32767, 32767, 32767);
        ex = '{32767, 0, 0, 0};
        get_row("sat_pos", 1'b1, -1, 0);
        send(-32768, -32768, -32768, -32768);
        ex = '{-32768, 0, 0, 0};
        get_row("sat_neg", 1'b1, -1, 0);

        // Backpressure: 5 stalled cycles at idx 1
        send(10, 20, 30, 40);
        ex = '{3200, -1425, 0, -125};
        get_row("bp", 1'b1, 1, 5);

        // Busy rejection: in_valid held high through row A into row B
        exa = '{352, -55, 96, 469};
        @(negedge clk);
        chk("busy_a_in_ready", bus.in_ready, 1);
        bus.in_data  = pack(5, -3, 7, 2);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_data = pack(1, 0, 0, -1);
        n = 0;
        got = 0;
        took = 1'b0;
        while (n < 40 && !took) begin
            if (bus.out_valid) begin
                chk("busy_a_data", $signed(bus.out_data), exa[got]);
                chk("busy_a_idx", bus.out_idx, got);
                got++;
            end
            if (bus.in_ready) took = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("busy_a_count", got, 4);
        chk("busy_period", n + 1, 14);
        @(negedge clk);
        bus.in_valid = 1'b0;
        ex = '{0, 83, 0, 36};
        get_row("busy_b", 1'b1, -1, 0);

        // Reset during MAC step 4
        send(7, 7, 7, 7);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", bus.in_ready, 1);
        chk("postrst_out_valid", bus.out_valid, 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        chk("postrst_no_partial", cnt, 0);
        send(1, 1, 1, 1);
        ex = '{128, 0, 0, 0};
        get_row("postrst_row", 1'b1, -1, 0);

        // SHIFT=0 build
        ex = '{0, 166, 0, 72};
        @(negedge clk);
        chk("s0_in_ready", bus0.in_ready, 1);
        bus0.in_data  = pack(1, 0, 0, -1);
        bus0.in_valid = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        n = 0;
        got = 0;
        while (got < 4 && n < 30) begin
            if (bus0.out_valid) begin
                chk("s0_data", $signed(bus0.out_data), ex[got]);
                chk("s0_idx", bus0.out_idx, got);
                got++;
            end
            @(negedge clk);
            n++;
        end
        chk("s0_count", got, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
